// File: rtl/inflate_pkg.sv
// rtl/inflate_pkg.sv - shared inflate constants, state encoding and helpers
// Purpose: table geometry (max code length, field widths) and the build/decode
//   state enum shared by huffman_table_builder, huffman_decoder and the stream
//   controller. No ports.
package inflate_pkg;

  function automatic int ceilLog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int HUFF_CODE_LEN = 8;
  localparam int LEN_W         = ceilLog2(HUFF_CODE_LEN + 1);
  localparam int SYM_W         = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    CODES = 3'd2,
    CLEAR = 3'd3,
    FILL  = 3'd4,
    DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/huffman_table_builder.sv
// rtl/huffman_table_builder.sv - canonical Huffman lookup table builder
// Purpose: takes one code length per symbol, derives canonical codes and writes
//   the full 2**HUFF_CODE_LEN entry decode table {symbol, length}.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   start, num_syms            begin a build with num_syms symbols (IDLE only)
//   len_vld, len_in, len_rdy   code-length input handshake (LOAD only)
//   tbl_we, tbl_addr,          registered table write port; CLEAR writes
//   tbl_sym, tbl_len           len 0 everywhere, FILL writes real entries
//   busy, done, err            status: not idle / end pulse / build failed
module huffman_table_builder
  import inflate_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     start,
  input  logic [SYM_W:0]           num_syms,
  input  logic                     len_vld,
  input  logic [LEN_W-1:0]         len_in,
  output logic                     len_rdy,
  output logic                     tbl_we,
  output logic [HUFF_CODE_LEN-1:0] tbl_addr,
  output logic [SYM_W-1:0]         tbl_sym,
  output logic [LEN_W-1:0]         tbl_len,
  output logic                     busy,
  output logic                     done,
  output logic                     err
);

  localparam int N    = HUFF_CODE_LEN;
  localparam int NSYM = 2 ** SYM_W;

  state_e               state_q, state_d;
  logic                 err_q, err_d;
  logic [SYM_W:0]       num_q, num_d, idx_q, idx_d;
  logic [SYM_W-1:0]     s_q, s_d;
  logic [LEN_W-1:0]     b_q, b_d;
  logic [N-1:0]         cnt_q, cnt_d;     // CLEAR address, then FILL replica index j
  logic [N:0]           code_q, code_d;
  logic signed [N+1:0]  left_q, left_d;
  logic                 we_q, we_d;
  logic [N-1:0]         addr_q, addr_d;
  logic [SYM_W-1:0]     sym_q, sym_d;
  logic [LEN_W-1:0]     wlen_q, wlen_d;

  logic [LEN_W-1:0]     len_mem_q [NSYM];
  logic [N:0]           bl_count_q [N+1];
  logic [N:0]           next_code_q [N+1];

  logic                 load_fire, bl_clr, code_step, fill_bump;
  logic [N:0]           bl_prev, code_new, span;
  logic signed [N+1:0]  left_new;
  logic [LEN_W-1:0]     cur_len, shamt;
  logic [N-1:0]         fill_addr;
  logic                 last_j;

  // CODES-step arithmetic; bl_count[0] is treated as zero
  assign bl_prev  = (b_q == LEN_W'(1)) ? '0 : bl_count_q[b_q - LEN_W'(1)];
  assign code_new = (code_q + bl_prev) << 1;
  assign left_new = (left_q <<< 1) - $signed({1'b0, bl_count_q[b_q]});

  // FILL: a code of length L covers 2**(N-L) consecutive table entries
  assign cur_len   = len_mem_q[s_q];
  assign shamt     = LEN_W'(N) - cur_len;
  assign span      = (N+1)'(1) << shamt;
  assign fill_addr = N'(next_code_q[cur_len] << shamt) | cnt_q;
  assign last_j    = ({1'b0, cnt_q} == (span - (N+1)'(1)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    err_d     = err_q;
    num_d     = num_q;
    idx_d     = idx_q;
    s_d       = s_q;
    b_d       = b_q;
    cnt_d     = cnt_q;
    code_d    = code_q;
    left_d    = left_q;
    we_d      = 1'b0;
    addr_d    = '0;
    sym_d     = '0;
    wlen_d    = '0;
    len_rdy   = 1'b0;
    load_fire = 1'b0;
    bl_clr    = 1'b0;
    code_step = 1'b0;
    fill_bump = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          num_d  = num_syms;
          idx_d  = '0;
          s_d    = '0;
          b_d    = LEN_W'(1);
          cnt_d  = '0;
          code_d = '0;
          left_d = (N+2)'(1);
          err_d  = 1'b0;
          bl_clr = 1'b1;
          if (num_syms == '0 || num_syms > (SYM_W+1)'(NSYM)) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = LOAD;
          end
        end
      end
      LOAD: begin
        len_rdy = 1'b1;
        if (len_vld) begin
          load_fire = 1'b1;
          idx_d     = idx_q + (SYM_W+1)'(1);
          if (len_in > LEN_W'(N)) err_d = 1'b1;
          if ((idx_q + (SYM_W+1)'(1)) == num_q) state_d = CODES;
        end
      end
      CODES: begin
        code_step = 1'b1;
        code_d    = code_new;
        b_d       = b_q + LEN_W'(1);
        // once oversubscribed, freeze left so it cannot wrap
        if (left_q >= 0) begin
          left_d = left_new;
          if (left_new < 0) err_d = 1'b1;
        end
        if (b_q == LEN_W'(N)) state_d = err_d ? DONE : CLEAR;
      end
      CLEAR: begin
        we_d   = 1'b1;
        addr_d = cnt_q;
        cnt_d  = cnt_q + N'(1);
        if (cnt_q == '1) state_d = FILL;
      end
      FILL: begin
        if (cur_len == '0) begin
          s_d = s_q + SYM_W'(1);
          if (({1'b0, s_q} + (SYM_W+1)'(1)) == num_q) state_d = DONE;
        end else begin
          we_d   = 1'b1;
          addr_d = fill_addr;
          sym_d  = s_q;
          wlen_d = cur_len;
          cnt_d  = cnt_q + N'(1);
          if (last_j) begin
            cnt_d     = '0;
            fill_bump = 1'b1;
            s_d       = s_q + SYM_W'(1);
            if (({1'b0, s_q} + (SYM_W+1)'(1)) == num_q) state_d = DONE;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q  <= 1'b0;
      num_q  <= '0;
      idx_q  <= '0;
      s_q    <= '0;
      b_q    <= '0;
      cnt_q  <= '0;
      code_q <= '0;
      left_q <= '0;
      we_q   <= 1'b0;
      addr_q <= '0;
      sym_q  <= '0;
      wlen_q <= '0;
      for (int i = 0; i <= N; i++) begin
        bl_count_q[i]  <= '0;
        next_code_q[i] <= '0;
      end
    end else begin
      err_q  <= err_d;
      num_q  <= num_d;
      idx_q  <= idx_d;
      s_q    <= s_d;
      b_q    <= b_d;
      cnt_q  <= cnt_d;
      code_q <= code_d;
      left_q <= left_d;
      we_q   <= we_d;
      addr_q <= addr_d;
      sym_q  <= sym_d;
      wlen_q <= wlen_d;
      if (bl_clr) begin
        for (int i = 0; i <= N; i++) bl_count_q[i] <= '0;
      end else if (load_fire && len_in != '0 && len_in <= LEN_W'(N)) begin
        bl_count_q[len_in] <= bl_count_q[len_in] + (N+1)'(1);
      end
      if (code_step)
        next_code_q[b_q] <= code_new;
      else if (fill_bump)
        next_code_q[cur_len] <= next_code_q[cur_len] + (N+1)'(1);
    end
  end

  // symbol lengths need no reset: every build overwrites the entries it reads
  always_ff @(posedge clk) begin
    if (load_fire) len_mem_q[idx_q[SYM_W-1:0]] <= len_in;
  end

  assign tbl_we   = we_q;
  assign tbl_addr = addr_q;
  assign tbl_sym  = sym_q;
  assign tbl_len  = wlen_q;
  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign err      = err_q;

endmodule

// File: tb/tb_huffman_table_builder.sv
// tb/tb_huffman_table_builder.sv - scoreboard bench for huffman_table_builder
module tb_huffman_table_builder;
  import inflate_pkg::*;

  logic                     clk = 1'b0;
  logic                     rst_n = 1'b0;
  logic                     start = 1'b0;
  logic [SYM_W:0]           num_syms = '0;
  logic                     len_vld = 1'b0;
  logic [LEN_W-1:0]         len_in = '0;
  logic                     len_rdy, tbl_we, busy, done, err;
  logic [HUFF_CODE_LEN-1:0] tbl_addr;
  logic [SYM_W-1:0]         tbl_sym;
  logic [LEN_W-1:0]         tbl_len;

  always #5 clk = ~clk;

  huffman_table_builder dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_syms(num_syms),
    .len_vld(len_vld), .len_in(len_in), .len_rdy(len_rdy),
    .tbl_we(tbl_we), .tbl_addr(tbl_addr), .tbl_sym(tbl_sym), .tbl_len(tbl_len),
    .busy(busy), .done(done), .err(err)
  );

  typedef struct packed {
    logic [7:0] addr;
    logic [4:0] sym;
    logic [3:0] len;
  } wr_t;

  wr_t        wq[$];
  logic       dq[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         writes_seen = 0;
  logic [3:0] lens_v [32];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: event occurred, expected none", name);
  endtask

  task automatic push_range(input int lo, input int hi, input int sym, input int len);
    wr_t w;
    for (int a = lo; a <= hi; a++) begin
      w.addr = 8'(a);
      w.sym  = 5'(sym);
      w.len  = 4'(len);
      wq.push_back(w);
    end
  endtask

  task automatic push_clear();
    push_range(0, 255, 0, 0);
  endtask

  // monitor: every write and every done pulse is checked against the queues
  always @(negedge clk) begin : monitor
    wr_t  e;
    logic ee;
    if (rst_n) begin
      if (tbl_we) begin
        writes_seen++;
        if (wq.size() == 0) fail_now("unexpected_write");
        else begin
          e = wq.pop_front();
          chk("wr_addr", 32'(tbl_addr), 32'(e.addr));
          chk("wr_sym",  32'(tbl_sym),  32'(e.sym));
          chk("wr_len",  32'(tbl_len),  32'(e.len));
        end
      end
      if (done) begin
        if (dq.size() == 0) fail_now("unexpected_done");
        else begin
          ee = dq.pop_front();
          chk("done_err", 32'(err), 32'(ee));
          chk("writes_missing", 32'(wq.size()), 32'd0);
          chk("len_rdy_at_done", 32'(len_rdy), 32'd0);
        end
      end
    end
  end

  task automatic do_build(input int n, input bit gaps, input bit poke);
    int w;
    @(negedge clk);
    start = 1'b1;
    num_syms = 6'(n);
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        len_vld = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      len_vld = 1'b1;
      len_in  = lens_v[i];
      w = 0;
      while (!len_rdy && w < 20) begin
        @(negedge clk);
        w++;
      end
      if (w == 20) fail_now("len_rdy_timeout");
      @(negedge clk);
    end
    len_vld = 1'b0;
    chk("len_rdy_after_load", 32'(len_rdy), 32'd0);
    if (poke) begin
      start = 1'b1;
      num_syms = 6'd1;
      len_vld = 1'b1;
      len_in = 4'd1;
      repeat (4) begin
        @(negedge clk);
        chk("len_rdy_poke", 32'(len_rdy), 32'd0);
      end
      start = 1'b0;
      len_vld = 1'b0;
    end
  endtask

  task automatic wait_done();
    int w;
    w = 0;
    while (!done && w < 3000) begin
      @(negedge clk);
      w++;
    end
    if (w == 3000) fail_now("done_timeout");
    else begin
      @(negedge clk);
      chk("busy_after_done", 32'(busy), 32'd0);
      chk("done_one_cycle", 32'(done), 32'd0);
    end
  endtask

  task automatic exp_case1();
    lens_v[0] = 4'd2; lens_v[1] = 4'd1; lens_v[2] = 4'd3; lens_v[3] = 4'd3;
    push_clear();
    push_range(8'h80, 8'hBF, 0, 2);
    push_range(8'h00, 8'h7F, 1, 1);
    push_range(8'hC0, 8'hDF, 2, 3);
    push_range(8'hE0, 8'hFF, 3, 3);
    dq.push_back(1'b0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_we"},   32'(tbl_we),   32'd0);
    chk({tag, "_addr"}, 32'(tbl_addr), 32'd0);
    chk({tag, "_sym"},  32'(tbl_sym),  32'd0);
    chk({tag, "_len"},  32'(tbl_len),  32'd0);
    chk({tag, "_busy"}, 32'(busy),     32'd0);
    chk({tag, "_done"}, 32'(done),     32'd0);
    chk({tag, "_err"},  32'(err),      32'd0);
    chk({tag, "_rdy"},  32'(len_rdy),  32'd0);
  endtask

  initial begin
    int w;
    int base;
    repeat (3) @(negedge clk);
    chk_idle_outputs("reset");
    rst_n = 1'b1;

    // case 1, with start and len_vld poked during CODES
    exp_case1();
    do_build(4, 1'b0, 1'b1);
    wait_done();

    // oversubscribed {1,1,1}
    lens_v[0] = 4'd1; lens_v[1] = 4'd1; lens_v[2] = 4'd1;
    dq.push_back(1'b1);
    do_build(3, 1'b0, 1'b0);
    wait_done();
    chk("err_held", 32'(err), 32'd1);

    // single symbol, length 1: incomplete code is legal
    lens_v[0] = 4'd1;
    push_clear();
    push_range(8'h00, 8'h7F, 0, 1);
    dq.push_back(1'b0);
    do_build(1, 1'b0, 1'b0);
    wait_done();

    // length above HUFF_CODE_LEN
    lens_v[0] = 4'd9;
    dq.push_back(1'b1);
    do_build(1, 1'b0, 1'b0);
    wait_done();

    // 32 symbols of length 8, without and with input gaps
    for (int rep = 0; rep < 2; rep++) begin
      for (int s = 0; s < 32; s++) lens_v[s] = 4'd8;
      push_clear();
      for (int s = 0; s < 32; s++) push_range(s, s, s, 8);
      dq.push_back(1'b0);
      do_build(32, rep[0], 1'b0);
      wait_done();
    end

    // reset in the middle of FILL, then a clean rerun
    exp_case1();
    base = writes_seen;
    do_build(4, 1'b0, 1'b0);
    w = 0;
    while (writes_seen < base + 266 && w < 2000) begin
      @(negedge clk);
      w++;
    end
    if (w == 2000) fail_now("fill_reach_timeout");
    #1 rst_n = 1'b0;
    #1 chk_idle_outputs("midreset");
    @(negedge clk);
    chk("midreset_busy_cycle", 32'(busy), 32'd0);
    wq.delete();
    dq.delete();
    rst_n = 1'b1;
    exp_case1();
    do_build(4, 1'b0, 1'b0);
    wait_done();

    // num_syms = 0 and num_syms = 33: immediate error
    for (int k = 0; k < 2; k++) begin
      dq.push_back(1'b1);
      @(negedge clk);
      start = 1'b1;
      num_syms = (k == 0) ? 6'd0 : 6'd33;
      @(negedge clk);
      start = 1'b0;
      chk("bad_num_done", 32'(done), 32'd1);
      chk("bad_num_err", 32'(err), 32'd1);
      @(negedge clk);
      chk("bad_num_done_fall", 32'(done), 32'd0);
      chk("bad_num_busy", 32'(busy), 32'd0);
    end

    repeat (3) @(negedge clk);
    chk("queues_drained", 32'(wq.size() + dq.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
